// File: rtl/reg_file.sv
// 32x32 register file with two combinational read ports, EX/MEM/WB operand
// forwarding and load-use stall detection.

module reg_file_port (
    input  logic        rst,
    input  logic        read_en,
    input  logic [4:0]  read_addr,
    input  logic [31:0] array_data,
    input  logic        ex_write_en,
    input  logic        ex_load,
    input  logic [4:0]  ex_write_addr,
    input  logic [31:0] ex_write_data,
    input  logic        mem_write_en,
    input  logic [4:0]  mem_write_addr,
    input  logic [31:0] mem_write_data,
    input  logic        write_en,
    input  logic [4:0]  write_addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        hazard
);
    logic ex_hit, mem_hit, wb_hit;

    assign ex_hit  = ex_write_en  && (read_addr == ex_write_addr);
    assign mem_hit = mem_write_en && (read_addr == mem_write_addr);
    assign wb_hit  = write_en     && (read_addr == write_addr);

    always_comb begin
        read_data = '0;
        hazard    = 1'b0;
        if (!rst && read_en && read_addr != 5'd0) begin
            hazard = ex_hit && ex_load;
            // A load in EX has no result yet; fall through to older stages.
            if (ex_hit && !ex_load)
                read_data = ex_write_data;
            else if (mem_hit)
                read_data = mem_write_data;
            else if (wb_hit)
                read_data = write_data;
            else
                read_data = array_data;
        end
    end
endmodule

module reg_file (
    input  logic        clk,
    input  logic        rst,
    input  logic        read_en_1,
    input  logic [4:0]  read_addr_1,
    input  logic        read_en_2,
    input  logic [4:0]  read_addr_2,
    input  logic        write_en,
    input  logic [4:0]  write_addr,
    input  logic [31:0] write_data,
    input  logic        ex_write_en,
    input  logic [4:0]  ex_write_addr,
    input  logic [31:0] ex_write_data,
    input  logic        ex_load,
    input  logic        mem_write_en,
    input  logic [4:0]  mem_write_addr,
    input  logic [31:0] mem_write_data,
    output logic [31:0] read_data_1,
    output logic [31:0] read_data_2,
    output logic        stall_request
);
    localparam int NUM_PORTS = 2;

    logic [31:0] regs [32];

    logic [NUM_PORTS-1:0]       read_en_v;
    logic [NUM_PORTS-1:0][4:0]  read_addr_v;
    logic [NUM_PORTS-1:0][31:0] array_v;
    logic [NUM_PORTS-1:0][31:0] data_v;
    logic [NUM_PORTS-1:0]       hazard_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= '0;
        end else if (write_en && write_addr != 5'd0) begin
            regs[write_addr] <= write_data;
        end
    end

    assign read_en_v   = {read_en_2, read_en_1};
    assign read_addr_v = {read_addr_2, read_addr_1};

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign array_v[p] = regs[read_addr_v[p]];

        reg_file_port u_port (
            .rst            (rst),
            .read_en        (read_en_v[p]),
            .read_addr      (read_addr_v[p]),
            .array_data     (array_v[p]),
            .ex_write_en    (ex_write_en),
            .ex_load        (ex_load),
            .ex_write_addr  (ex_write_addr),
            .ex_write_data  (ex_write_data),
            .mem_write_en   (mem_write_en),
            .mem_write_addr (mem_write_addr),
            .mem_write_data (mem_write_data),
            .write_en       (write_en),
            .write_addr     (write_addr),
            .write_data     (write_data),
            .read_data      (data_v[p]),
            .hazard         (hazard_v[p])
        );
    end

    assign read_data_1   = data_v[0];
    assign read_data_2   = data_v[1];
    assign stall_request = |hazard_v;
endmodule

// File: tb/tb_reg_file.sv
// Directed and randomized checks of reg_file against a behavioural model
// of the array, forwarding priority and load-use stall rule.

module tb_reg_file;
    logic        clk = 1'b0;
    logic        rst;
    logic        read_en_1, read_en_2;
    logic [4:0]  read_addr_1, read_addr_2;
    logic        write_en;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic        ex_write_en, ex_load;
    logic [4:0]  ex_write_addr;
    logic [31:0] ex_write_data;
    logic        mem_write_en;
    logic [4:0]  mem_write_addr;
    logic [31:0] mem_write_data;
    logic [31:0] read_data_1, read_data_2;
    logic        stall_request;

    logic [31:0] model [32];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    reg_file dut (
        .clk(clk), .rst(rst),
        .read_en_1(read_en_1), .read_addr_1(read_addr_1),
        .read_en_2(read_en_2), .read_addr_2(read_addr_2),
        .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
        .ex_write_en(ex_write_en), .ex_write_addr(ex_write_addr),
        .ex_write_data(ex_write_data), .ex_load(ex_load),
        .mem_write_en(mem_write_en), .mem_write_addr(mem_write_addr),
        .mem_write_data(mem_write_data),
        .read_data_1(read_data_1), .read_data_2(read_data_2),
        .stall_request(stall_request)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic en, input logic [4:0] a);
        if (rst || !en || a == 0) return 32'h0;
        if (ex_write_en && !ex_load && ex_write_addr == a) return ex_write_data;
        if (mem_write_en && mem_write_addr == a) return mem_write_data;
        if (write_en && write_addr == a) return write_data;
        return model[a];
    endfunction

    function automatic logic exp_stall();
        logic h1, h2;
        h1 = read_en_1 && read_addr_1 != 0 && ex_write_en && ex_load && read_addr_1 == ex_write_addr;
        h2 = read_en_2 && read_addr_2 != 0 && ex_write_en && ex_load && read_addr_2 == ex_write_addr;
        return !rst && (h1 || h2);
    endfunction

    task automatic check_model(input string tag);
        #1;
        chk({tag, "_rd1"}, read_data_1, exp_read(read_en_1, read_addr_1));
        chk({tag, "_rd2"}, read_data_2, exp_read(read_en_2, read_addr_2));
        chk({tag, "_stall"}, {31'd0, stall_request}, {31'd0, exp_stall()});
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (write_en && write_addr != 0) begin
            model[write_addr] = write_data;
        end
        #1;
    endtask

    task automatic idle();
        rst = 0; read_en_1 = 0; read_en_2 = 0; read_addr_1 = 0; read_addr_2 = 0;
        write_en = 0; write_addr = 0; write_data = 0;
        ex_write_en = 0; ex_load = 0; ex_write_addr = 0; ex_write_data = 0;
        mem_write_en = 0; mem_write_addr = 0; mem_write_data = 0;
    endtask

    task automatic read2(input logic [4:0] a1, input logic [4:0] a2);
        read_en_1 = 1; read_addr_1 = a1; read_en_2 = 1; read_addr_2 = a2;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        idle();
        // Reset with busy inputs including a load-use hazard.
        rst = 1; read2(5'd9, 5'd9);
        write_en = 1; write_addr = 9; write_data = 32'hDEADBEEF;
        ex_write_en = 1; ex_load = 1; ex_write_addr = 9;
        mem_write_en = 1; mem_write_addr = 9; mem_write_data = 32'h1111;
        check_model("rst_busy");
        chk("rst_rd1_zero", read_data_1, 32'h0);
        chk("rst_stall_zero", {31'd0, stall_request}, 32'h0);
        tick();
        tick();

        // Every address reads zero after reset.
        idle();
        for (int a = 0; a < 32; a++) begin
            read2(a[4:0], 5'(31 - a));
            #1;
            chk("post_rst_rd1", read_data_1, 32'h0);
            chk("post_rst_rd2", read_data_2, 32'h0);
            chk("post_rst_stall", {31'd0, stall_request}, 32'h0);
        end
        tick();

        // WB write-through, then array read.
        idle(); read2(5'd5, 5'd5);
        write_en = 1; write_addr = 5; write_data = 32'h12345678;
        check_model("wb_bypass");
        chk("wb_bypass_const", read_data_1, 32'h12345678);
        tick();
        write_en = 0;
        check_model("wb_array");
        chk("wb_array_const", read_data_2, 32'h12345678);
        tick();

        // Forwarding priority EX > MEM > WB.
        idle(); read2(5'd8, 5'd8);
        ex_write_en = 1; ex_write_addr = 8; ex_write_data = 32'hAAAA0000;
        mem_write_en = 1; mem_write_addr = 8; mem_write_data = 32'hBBBB0000;
        write_en = 1; write_addr = 8; write_data = 32'hCCCC0000;
        check_model("fwd_ex");
        chk("fwd_ex_const", read_data_1, 32'hAAAA0000);
        ex_write_en = 0;
        #1 chk("fwd_mem_const", read_data_2, 32'hBBBB0000);
        mem_write_en = 0;
        #1 chk("fwd_wb_const", read_data_1, 32'hCCCC0000);
        tick();
        write_en = 0;
        check_model("fwd_array");
        chk("fwd_array_const", read_data_1, 32'hCCCC0000);

        // Load-use stall.
        idle(); ex_write_en = 1; ex_load = 1; ex_write_addr = 9;
        read_en_2 = 1; read_addr_2 = 9;
        check_model("stall_on");
        chk("stall_on_const", {31'd0, stall_request}, 32'h1);
        read_en_2 = 0;
        #1 chk("stall_off_en", {31'd0, stall_request}, 32'h0);
        read_en_2 = 1; read_addr_2 = 0; ex_write_addr = 0;
        #1 chk("stall_off_r0", {31'd0, stall_request}, 32'h0);
        tick();

        // Register zero is immutable.
        idle(); read2(5'd0, 5'd0);
        write_en = 1; write_addr = 0; write_data = 32'hFFFFFFFF;
        ex_write_en = 1; ex_write_data = 32'hFFFFFFFF;
        mem_write_en = 1; mem_write_data = 32'hFFFFFFFF;
        check_model("r0_fwd");
        tick();
        idle(); read2(5'd0, 5'd0);
        check_model("r0_after");
        chk("r0_after_const", read_data_2, 32'h0);

        // Reset during a stall wipes the array.
        idle(); write_en = 1; write_addr = 3; write_data = 32'h55;
        tick();
        idle(); read2(5'd3, 5'd3); ex_write_en = 1; ex_load = 1; ex_write_addr = 3;
        check_model("pre_rst_stall");
        chk("pre_rst_stall_const", {31'd0, stall_request}, 32'h1);
        rst = 1;
        check_model("mid_rst");
        chk("mid_rst_stall_const", {31'd0, stall_request}, 32'h0);
        tick();
        idle(); read2(5'd3, 5'd3);
        check_model("post_rst3");
        chk("post_rst3_const", read_data_1, 32'h0);
        tick();

        // Randomized traffic on a narrow address window to provoke collisions.
        for (int n = 0; n < 400; n++) begin
            rst            = ($urandom_range(0, 49) == 0);
            read_en_1      = $urandom_range(0, 3) != 0;
            read_en_2      = $urandom_range(0, 3) != 0;
            read_addr_1    = 5'($urandom_range(0, 7));
            read_addr_2    = 5'($urandom_range(0, 7));
            write_en       = $urandom_range(0, 1);
            write_addr     = 5'($urandom_range(0, 7));
            write_data     = $urandom;
            ex_write_en    = $urandom_range(0, 1);
            ex_load        = $urandom_range(0, 2) == 0;
            ex_write_addr  = 5'($urandom_range(0, 7));
            ex_write_data  = $urandom;
            mem_write_en   = $urandom_range(0, 1);
            mem_write_addr = 5'($urandom_range(0, 7));
            mem_write_data = $urandom;
            check_model("rand");
            tick();
        end

        // Final sweep of array contents.
        idle();
        for (int a = 0; a < 32; a++) begin
            read2(a[4:0], a[4:0]);
            check_model("final");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
